// File: rtl/blit_pkg.sv
// Shared types and bit positions for the blitter collision-stop sequencer.
package blit_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STOPPED = 2'd2,
    ABORT   = 2'd3
  } blit_state_e;

  // Stop control register bits (gpu_din)
  localparam int CTL_RESUME = 0;
  localparam int CTL_ABORT  = 1;
  localparam int CTL_STOPEN = 2;
  localparam int CTL_CLRCNT = 3;

  // Status word bits (gpu_dout); the count occupies bits 15:8
  localparam int ST_STOPEN    = 0;
  localparam int ST_STOPPED   = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_DRV_RESET = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/blit_collide_seq.sv
// Gates blitter destination writes and halts the blit on a data-compare
// collision until the GPU resumes it or aborts it with a timed blitter reset.
module blit_collide_seq
  import blit_pkg::*;
#(
  parameter int ABORT_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic             clk_0,
  input  logic             reset,
  input  logic             start,
  input  logic             wr_req,
  input  logic             last,
  input  logic             nowrite,
  input  logic             ctrlld,
  input  logic [3:0]       gpu_din,
  input  logic             statrd,
  output logic             wr_gnt,
  output logic             busy,
  output logic             stopped,
  output logic             drv_reset,
  output logic             done,
  output logic [CNT_W-1:0] coll_count,
  output logic [15:0]      gpu_dout
);

  blit_state_e state, next_state;
  logic        stopen;
  logic        skip;
  logic [3:0]  abort_cnt;
  logic        collision;
  logic [7:0]  cnt8;
  logic [15:0] status;

  always_ff @(posedge clk_0) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    wr_gnt     = 1'b0;
    collision  = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = RUN;
      end
      RUN: begin
        collision = wr_req & nowrite & stopen & ~skip;
        wr_gnt    = wr_req & ~collision;
        if (collision) begin
          next_state = STOPPED;
        end else if (wr_req && last) begin
          next_state = IDLE;
        end
      end
      STOPPED: begin
        if (ctrlld && gpu_din[CTL_ABORT]) begin
          next_state = ABORT;
        end else if (ctrlld && gpu_din[CTL_RESUME]) begin
          next_state = RUN;
        end
      end
      ABORT: begin
        // The edge that takes the timer to zero also leaves ABORT
        if (abort_cnt <= 4'd1) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_0) begin
    if (reset) begin
      stopen    <= 1'b0;
      skip      <= 1'b0;
      abort_cnt <= 4'd0;
      done      <= 1'b0;
    end else begin
      done <= (state == RUN) & wr_req & last & ~collision;
      if (ctrlld) stopen <= gpu_din[CTL_STOPEN];
      // skip lets the collided write through once after a resume
      if (state == STOPPED && next_state == RUN) begin
        skip <= 1'b1;
      end else if (state == RUN && (wr_gnt || next_state != RUN)) begin
        skip <= 1'b0;
      end
      if (state == STOPPED && next_state == ABORT) begin
        abort_cnt <= 4'(ABORT_CYCLES);
      end else if (state == ABORT && abort_cnt != 4'd0) begin
        abort_cnt <= abort_cnt - 4'd1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_coll_cnt (
    .clk   (clk_0),
    .reset (reset),
    .inc   (collision),
    .clr   (ctrlld & gpu_din[CTL_CLRCNT]),
    .count (coll_count)
  );

  assign busy      = (state != IDLE);
  assign stopped   = (state == STOPPED);
  assign drv_reset = (state == ABORT);

  generate
    if (CNT_W >= 8) begin : g_cnt_trunc
      assign cnt8 = coll_count[7:0];
    end else begin : g_cnt_ext
      assign cnt8 = {{(8 - CNT_W){1'b0}}, coll_count};
    end
  endgenerate

  always_comb begin
    status               = 16'h0000;
    status[ST_STOPEN]    = stopen;
    status[ST_STOPPED]   = stopped;
    status[ST_BUSY]      = busy;
    status[ST_DRV_RESET] = drv_reset;
    status[15:8]         = cnt8;
  end

  assign gpu_dout = statrd ? status : 16'h0000;

endmodule
